psw_ctx_stack: RTL
==================

// Module: psw_ctx_stack
// PURPOSE
//  Parametrised 8051 program status word with a hardware context stack.
//  Holds CY/AC/F0/RS1:0/OV/F1/P and updates flags from the ALU.
//  Saves and restores the PSW on interrupt entry (ctx_push) and RETI (ctx_pop),
//  removing the software PUSH/POP PSW overhead. Sits beside the ACC/B SFRs on the SFR bus.
// PARAMETERS
//  ACC_WIDTH  8       width of acc_in, the parity source
//  CTX_DEPTH  4       context stack entries (>=1), one per nested interrupt level
//  SFR_ADDR   8'hD0   byte address of the PSW; bit-space base is SFR_ADDR[7:3]
//  LW                 localparam = $clog2(CTX_DEPTH+1)
// PORTS
//  clock         in   1          rising-edge clock
//  reset         in   1          synchronous, active-low reset
//  carry_in      in   1          ALU carry
//  aux_carry_in  in   1          ALU auxiliary carry
//  overflow_in   in   1          ALU overflow
//  flag_set      in   2          00 none, 01 CY, 10 CY+OV, 11 CY+OV+AC
//  data_in       in   8          SFR byte write data
//  bit_in        in   1          SFR bit write data
//  addr          in   8          SFR byte or bit address
//  write_en      in   1          SFR write strobe
//  write_bit_en  in   1          qualifies write_en as a bit write
//  acc_in        in   ACC_WIDTH  accumulator value, used for parity
//  ctx_push      in   1          interrupt entry: save PSW
//  ctx_pop       in   1          RETI: restore PSW
//  err_clr       in   1          clear sticky ctx_ovf/ctx_unf
//  psw_data      out  8          current PSW
//  bank_sel      out  2          psw_data[4:3], register bank base
//  ctx_level     out  LW         number of stored contexts
//  ctx_full      out  1          ctx_level == CTX_DEPTH
//  ctx_empty     out  1          ctx_level == 0
//  ctx_ovf       out  1          sticky: push attempted while full
//  ctx_unf       out  1          sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (reset==0 at an edge):
//    - psw_data = 8'h00, ctx_level = 0, ctx_empty = 1, ctx_full = 0, ctx_ovf = ctx_unf = 0.
//    - All stack entries are cleared to 0.
//    - Reset overrides every other input, including a push or pop in the same cycle.
//  - All outputs are registered. One cycle latency from any input to psw_data.
//  - PSW[7:1] next-value priority, highest first:
//    1. Valid pop: PSW[7:1] = top entry[7:1].
//    2. Byte write: write_en & !write_bit_en & addr==SFR_ADDR -> PSW[7:1] = data_in[7:1].
//    3. Bit write: write_en & write_bit_en & addr[7:3]==SFR_ADDR[7:3] -> PSW[addr[2:0]] = bit_in.
//       A bit write to bit 0 has no effect.
//    4. flag_set: 01 writes CY; 10 writes CY and OV; 11 writes CY, OV and AC.
//  - PSW[0] = ^acc_in every cycle, including pop and write cycles. Parity is never restored from the stack.
//  - Push (ctx_push & !ctx_pop):
//    - If not full: stack[ctx_level] = PSW value before this edge, then ctx_level++.
//      Writes and flag updates in the same cycle still apply to the live PSW.
//    - If full: the push is dropped, ctx_ovf is set, and the stack is unchanged.
//  - Pop (ctx_pop & !ctx_push):
//    - If not empty: restore from stack[ctx_level-1], then ctx_level--.
//    - If empty: the pop is dropped, ctx_unf is set, and the PSW follows priorities 2-4.
//  - Push and pop in the same cycle (swap):
//    - If not empty: PSW[7:1] = top[7:1], the top entry is replaced with the pre-edge PSW, and ctx_level is unchanged.
//    - If empty: the operation behaves as a plain push.
//  - Error flags:
//    - err_clr clears ctx_ovf/ctx_unf.
//    - A new error in the same cycle as err_clr wins, so the flag stays set.
//  - Writes to addresses other than the PSW byte or its bit range are ignored.
// TESTING
//  - Reset: hold reset=0 for 2 cycles with push=1 -> psw=00, level=0, empty=1, no ovf.
//  - Flags:
//    - acc_in=8'h07, flag_set=11, cy=1, ov=1, ac=0 -> psw=8'h85 after 1 cycle.
//    - Then acc_in=8'h03, flag_set=00 -> psw=8'h84.
//  - Byte/bit writes:
//    - Byte write D0 <- 8'hFF with acc_in parity 0 -> psw=8'hFE.
//    - Then bit write addr D3, bit_in=0 -> psw=8'hF6, bank_sel=2'b10.
//    - Bit write to D0 -> no change.
//  - Nesting (CTX_DEPTH=4):
//    - Push with psw=08, then 10, then 18, then 00 -> level=4, full=1.
//    - 5th push -> ovf=1, level stays 4.
//    - Pop four times -> psw[7:1] = 00,18,10,08 in sequence, empty=1.
//    - 5th pop -> unf=1, psw unchanged.
//  - Collisions:
//    - Pop and byte write FF in the same cycle with top=08 -> psw[7:1] from 08, i.e. pop wins.
//    - Push+pop with top=10, psw=18 -> psw=10, top=18, level unchanged.
//    - err_clr plus an illegal pop in the same cycle -> unf stays 1.

Source files
------------

// File: rtl/psw_ctx_stack_if.sv
// SFR-bus, ALU-flag and context-stack signals of the PSW block.
// The master drives the requests; the slave (the PSW) returns its status.
interface psw_ctx_stack_if #(
   parameter int ACC_WIDTH = 8,
   parameter int CTX_DEPTH = 4
);
   localparam int LW = $clog2(CTX_DEPTH + 1);

   logic                 carry_in;
   logic                 aux_carry_in;
   logic                 overflow_in;
   logic [1:0]           flag_set;
   logic [7:0]           data_in;
   logic                 bit_in;
   logic [7:0]           addr;
   logic                 write_en;
   logic                 write_bit_en;
   logic [ACC_WIDTH-1:0] acc_in;
   logic                 ctx_push;
   logic                 ctx_pop;
   logic                 err_clr;
   logic [7:0]           psw_data;
   logic [1:0]           bank_sel;
   logic [LW-1:0]        ctx_level;
   logic                 ctx_full;
   logic                 ctx_empty;
   logic                 ctx_ovf;
   logic                 ctx_unf;

   modport master (
      output carry_in, aux_carry_in, overflow_in, flag_set, data_in, bit_in,
             addr, write_en, write_bit_en, acc_in, ctx_push, ctx_pop, err_clr,
      input  psw_data, bank_sel, ctx_level, ctx_full, ctx_empty, ctx_ovf, ctx_unf
   );

   modport slave (
      input  carry_in, aux_carry_in, overflow_in, flag_set, data_in, bit_in,
             addr, write_en, write_bit_en, acc_in, ctx_push, ctx_pop, err_clr,
      output psw_data, bank_sel, ctx_level, ctx_full, ctx_empty, ctx_ovf, ctx_unf
   );
endinterface

// File: rtl/psw_ctx_stack.sv
// 8051 program status word with a hardware context stack that saves the PSW on
// interrupt entry and restores it on RETI; parity always tracks the accumulator.
module psw_ctx_stack #(
   parameter int         ACC_WIDTH = 8,
   parameter int         CTX_DEPTH = 4,
   parameter logic [7:0] SFR_ADDR  = 8'hD0
) (
   input  logic           clock,
   input  logic           reset,
   psw_ctx_stack_if.slave bus
);
   localparam int LW = $clog2(CTX_DEPTH + 1);

   function automatic logic parity(input logic [ACC_WIDTH-1:0] v);
      return ^v;
   endfunction

   logic [7:0]    psw_q, psw_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    stack_q [CTX_DEPTH];
   logic [7:0]    stack_d [CTX_DEPTH];
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic       full, empty, push_req, do_push, do_pop, do_swap, ovf_evt, unf_evt;
   logic       byte_hit, bit_hit;
   logic [7:0] top;

   always_comb begin
      full     = (level_q == LW'(CTX_DEPTH));
      empty    = (level_q == '0);
      // A swap on an empty stack degenerates to a plain push.
      push_req = bus.ctx_push & (~bus.ctx_pop | empty);
      do_push  = push_req & ~full;
      ovf_evt  = push_req & full;
      do_pop   = bus.ctx_pop & ~bus.ctx_push & ~empty;
      unf_evt  = bus.ctx_pop & ~bus.ctx_push & empty;
      do_swap  = bus.ctx_pop & bus.ctx_push & ~empty;
      byte_hit = bus.write_en & ~bus.write_bit_en & (bus.addr == SFR_ADDR);
      bit_hit  = bus.write_en & bus.write_bit_en & (bus.addr[7:3] == SFR_ADDR[7:3]);

      top = '0;
      for (int i = 0; i < CTX_DEPTH; i++) begin
         if (LW'(i) == level_q - 1'b1) top = stack_q[i];
      end

      psw_d   = psw_q;
      level_d = level_q;
      stack_d = stack_q;

      if (do_pop | do_swap) begin
         psw_d = top;
      end else if (byte_hit) begin
         psw_d = bus.data_in;
      end else if (bit_hit) begin
         if (bus.addr[2:0] != 3'd0) psw_d[bus.addr[2:0]] = bus.bit_in;
      end else begin
         case (bus.flag_set)
            2'b01: psw_d[7] = bus.carry_in;
            2'b10: begin
               psw_d[7] = bus.carry_in;
               psw_d[2] = bus.overflow_in;
            end
            2'b11: begin
               psw_d[7] = bus.carry_in;
               psw_d[6] = bus.aux_carry_in;
               psw_d[2] = bus.overflow_in;
            end
            default: ;
         endcase
      end
      psw_d[0] = parity(bus.acc_in);

      // The stack always captures the PSW as it was before this edge.
      for (int i = 0; i < CTX_DEPTH; i++) begin
         if (do_push && LW'(i) == level_q) stack_d[i] = psw_q;
         if (do_swap && LW'(i) == level_q - 1'b1) stack_d[i] = psw_q;
      end

      if (do_push) level_d = level_q + 1'b1;
      else if (do_pop) level_d = level_q - 1'b1;

      ovf_d = ovf_evt | (ovf_q & ~bus.err_clr);
      unf_d = unf_evt | (unf_q & ~bus.err_clr);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         psw_q   <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < CTX_DEPTH; i++) stack_q[i] <= '0;
      end else begin
         psw_q   <= psw_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         stack_q <= stack_d;
      end
   end

   assign bus.psw_data  = psw_q;
   assign bus.bank_sel  = psw_q[4:3];
   assign bus.ctx_level = level_q;
   assign bus.ctx_full  = (level_q == LW'(CTX_DEPTH));
   assign bus.ctx_empty = (level_q == '0);
   assign bus.ctx_ovf   = ovf_q;
   assign bus.ctx_unf   = unf_q;
endmodule
